// File: rtl/uart_receiver.sv
// uart_receiver
//   UART receive stage. Oversamples the serial line with a 16x tick and
//   recovers 1 start bit, 8 data bits (MSB first), an optional even-parity
//   bit and 1 stop bit. Each good byte is delivered with a one-cycle valid
//   pulse. Malformed frames raise a one-cycle error pulse instead.
//
//   Compile-time option:
//     UART_RX_PARITY_EN  when defined, an even-parity bit is expected between
//                        the data and the stop bit and parity_err is active.
//                        When undefined, the frame is 10 bits and parity_err
//                        is tied low.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-low reset
//   rx_tick     in   1  one-clk pulse at 16x the bit rate
//   rx_in       in   1  serial line, idle high, asynchronous
//   RX_BYTE     out  8  last correctly received byte, held between frames
//   RX_VALID    out  1  one-clk pulse when RX_BYTE is updated
//   RX_BUSSY    out  1  high while a frame is being received
//   frame_err   out  1  one-clk pulse when the stop bit samples low
//   parity_err  out  1  one-clk pulse on parity mismatch (0 without parity)

module uart_receiver (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_tick,
   input  logic       rx_in,
   output logic [7:0] RX_BYTE,
   output logic       RX_VALID,
   output logic       RX_BUSSY,
   output logic       frame_err,
   output logic       parity_err
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t     state_r, state_s;
   logic       sync1_r, sync2_r, prev_r;
   logic       fall_s;
   logic       tick_mid_s, tick_end_s;
   logic [3:0] cnt_r, cnt_s, cnt_inc_s;
   logic [2:0] bitn_r, bitn_s;
   logic [7:0] sh_r, sh_s;
   logic [7:0] byte_r, byte_s;
   logic       valid_r, valid_s;
   logic       busy_r;
   logic       ferr_r, ferr_s;

`ifdef UART_RX_PARITY_EN
   logic       perr_r, perr_s;
   logic       perr_pulse_r, perr_pulse_s;

   // Even parity: the expected parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction
`endif

   // A falling edge of the synchronised line is the only thing that starts a
   // frame; a line that simply stays low never retriggers.
   assign fall_s     = prev_r & ~sync2_r;
   assign tick_mid_s = rx_tick & (cnt_r == 4'd7);
   assign tick_end_s = rx_tick & (cnt_r == 4'd15);
   assign cnt_inc_s  = rx_tick ? (cnt_r + 4'd1) : cnt_r;

   // Next-state and datapath decisions for the receive FSM.
   always_comb begin
      state_s = state_r;
      bitn_s  = bitn_r;
      sh_s    = sh_r;
      byte_s  = byte_r;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_s       = perr_r;
      perr_pulse_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_s = ST_START;
`ifdef UART_RX_PARITY_EN
               perr_s  = 1'b0;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            // Mid-start-bit check rejects short low glitches.
            if (tick_mid_s) begin
               if (sync2_r) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_DATA;
                  bitn_s  = 3'd0;
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_end_s) begin
               sh_s   = {sh_r[6:0], sync2_r};
               bitn_s = bitn_r + 3'd1;
               if (bitn_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_s = ST_PARITY;
`else
                  state_s = ST_STOP;
`endif
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick_end_s) begin
               perr_s  = perr_r | (sync2_r != even_parity(sh_r));
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_end_s) begin
               state_s = ST_IDLE;
               // A low stop bit outranks a parity error: only one flag per frame.
               if (!sync2_r) begin
                  ferr_s = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (perr_r) begin
                  perr_pulse_s = 1'b1;
`endif
               end else begin
                  byte_s  = sh_r;
                  valid_s = 1'b1;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // The tick counter restarts on every state change.
      if (state_s != state_r) begin
         cnt_s = 4'd0;
      end else begin
         cnt_s = cnt_inc_s;
      end
   end

   // State, synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
         cnt_r   <= 4'd0;
         bitn_r  <= 3'd0;
         sh_r    <= 8'd0;
         byte_r  <= 8'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_r       <= 1'b0;
         perr_pulse_r <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         sync1_r <= rx_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         cnt_r   <= cnt_s;
         bitn_r  <= bitn_s;
         sh_r    <= sh_s;
         byte_r  <= byte_s;
         valid_r <= valid_s;
         busy_r  <= (state_s != ST_IDLE);
         ferr_r  <= ferr_s;
`ifdef UART_RX_PARITY_EN
         perr_r       <= perr_s;
         perr_pulse_r <= perr_pulse_s;
`endif
      end
   end

   assign RX_BYTE   = byte_r;
   assign RX_VALID  = valid_r;
   assign RX_BUSSY  = busy_r;
   assign frame_err = ferr_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_pulse_r;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Self-checking bench for uart_receiver. Frames are described at the byte
//   level (data, stop-bit good/bad, parity good/bad); the expected outcome of
//   each frame, its tick latency and the held RX_BYTE value come from a
//   queue-based reference model. Honours UART_RX_PARITY_EN like the design.

module tb_uart_receiver;

   logic       clk;
   logic       rst;
   logic       rx_tick;
   logic       rx_in;
   logic [7:0] RX_BYTE;
   logic       RX_VALID;
   logic       RX_BUSSY;
   logic       frame_err;
   logic       parity_err;

`ifdef UART_RX_PARITY_EN
   localparam int FRAME_TICKS = 168;
`else
   localparam int FRAME_TICKS = 152;
`endif

   typedef struct {
      int       kind;        // 0 good byte, 1 frame error, 2 parity error
      bit [7:0] data;
      int       start_tick;
   } exp_evt_t;

   exp_evt_t exp_q[$];
   bit [7:0] last_byte;
   int       tick_cnt;
   bit [1:0] tdiv;
   int       n_tests;
   int       n_fail;

   uart_receiver dut (
      .clk        (clk),
      .rst        (rst),
      .rx_tick    (rx_tick),
      .rx_in      (rx_in),
      .RX_BYTE    (RX_BYTE),
      .RX_VALID   (RX_VALID),
      .RX_BUSSY   (RX_BUSSY),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 16x tick: one pulse every 4 clocks, changed on the falling edge.
   initial begin
      tdiv    = 2'd0;
      rx_tick = 1'b0;
   end
   always @(negedge clk) begin
      tdiv    <= tdiv + 2'd1;
      rx_tick <= (tdiv == 2'd3);
   end

   initial tick_cnt = 0;
   always @(posedge clk) begin
      if (rx_tick) tick_cnt <= tick_cnt + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Waits for n ticks seen by the DUT, then steps just past that edge.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!rx_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive_bit(input bit b);
      rx_in = b;
      wait_ticks(16);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      wait_ticks(n);
   endtask

   // Drives one complete frame and queues the outcome the model predicts.
   task automatic send_frame(input bit [7:0] data, input bit stop_ok, input bit par_ok);
      exp_evt_t ev;
      ev.data       = data;
      ev.start_tick = tick_cnt;
      if (!stop_ok) ev.kind = 1;
`ifdef UART_RX_PARITY_EN
      else if (!par_ok) ev.kind = 2;
`endif
      else ev.kind = 0;
      exp_q.push_back(ev);
      drive_bit(1'b0);
      for (int i = 7; i >= 0; i--) begin
         drive_bit(data[i]);
         if (i == 3) check_value("busy_mid", RX_BUSSY, 1);
      end
`ifdef UART_RX_PARITY_EN
      begin
         int ones;
         ones = 0;
         for (int i = 0; i < 8; i++) ones += data[i];
         drive_bit(((ones % 2) == 1) ^ !par_ok);
      end
`endif
      drive_bit(stop_ok);
   endtask

   // Output monitor: every pulse must match the next predicted frame outcome.
   always @(negedge clk) begin
      if (rst && (RX_VALID || frame_err || parity_err)) begin
         check_value("one_pulse", 32'(RX_VALID) + 32'(frame_err) + 32'(parity_err), 1);
         check_value("evt_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_evt_t ev;
            int       kind_got;
            ev = exp_q.pop_front();
            kind_got = RX_VALID ? 0 : (frame_err ? 1 : 2);
            check_value("evt_kind", kind_got, ev.kind);
            if (ev.kind == 0) last_byte = ev.data;
            check_value("rx_byte", RX_BYTE, last_byte);
            check_value("latency", tick_cnt - ev.start_tick, FRAME_TICKS);
            check_value("busy_fall", RX_BUSSY, 0);
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check_value({tag, "_byte"}, RX_BYTE, 0);
      check_value({tag, "_valid"}, RX_VALID, 0);
      check_value({tag, "_busy"}, RX_BUSSY, 0);
      check_value({tag, "_ferr"}, frame_err, 0);
      check_value({tag, "_perr"}, parity_err, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      last_byte = 8'd0;
      rst       = 1'b0;
      rx_in     = 1'b1;
      repeat (6) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;
      idle(20);

      // Reference frame 0xA5.
      send_frame(8'hA5, 1'b1, 1'b1);
      idle(10);

      // Short low glitch: START entered, abandoned at the mid-bit check.
      rx_in = 1'b0;
      wait_ticks(2);
      check_value("glitch_busy", RX_BUSSY, 1);
      wait_ticks(2);
      rx_in = 1'b1;
      wait_ticks(12);
      check_value("glitch_idle", RX_BUSSY, 0);
      check_value("glitch_byte", RX_BYTE, last_byte);
      idle(8);

      // Bad stop bit, then the line stays low: no retrigger.
      send_frame(8'h3C, 1'b0, 1'b1);
      wait_ticks(48);
      check_value("low_hold_busy", RX_BUSSY, 0);
      check_value("low_hold_byte", RX_BYTE, 8'hA5);
      idle(16);
      send_frame(8'h5A, 1'b1, 1'b1);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      idle(10);

      // Reset in the middle of bit 4 discards the frame.
      rx_in = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) drive_bit((i == 0) ? 1'b1 : 1'b0);
      rx_in = 1'b0;
      wait_ticks(8);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("mid_reset");
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      last_byte = 8'd0;
      rst = 1'b1;
      idle(16);
      send_frame(8'h81, 1'b1, 1'b1);
      idle(4);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      idle(4);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(4);
`endif

      // Randomised frames with random gaps and injected errors.
      for (int n = 0; n < 24; n++) begin
         bit [7:0] d;
         bit       s_ok;
         bit       p_ok;
         int       gap;
         d    = 8'($urandom_range(0, 255));
         s_ok = ($urandom_range(0, 4) != 0);
         p_ok = ($urandom_range(0, 3) != 0);
         send_frame(d, s_ok, p_ok);
         gap = s_ok ? $urandom_range(0, 20) : $urandom_range(1, 20);
         idle(gap);
      end

      idle(200);
      check_value("queue_empty", exp_q.size(), 0);
      check_value("final_busy", RX_BUSSY, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
